// File: rtl/myip_stepper_phase_gen_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared types and constants for the stepper phase generator:
//   - state_e      : sequencer state encoding (IDLE, RUN)
//   - PERIOD_MIN   : smallest period honoured; smaller requests are raised to it
//   - FULL_TABLE   : 4-entry full-step coil patterns {B', A', B, A}
//   - HALF_TABLE   : 8-entry half-step coil patterns
//   - *_IDX_W      : phase-index widths for each table
// Optional feature macro used by the design: STEPPER_HALF_STEP_EN.
// -----------------------------------------------------------------------------
package stepper_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned PERIOD_MIN = 2;

    localparam int FULL_IDX_W = 2;
    localparam int HALF_IDX_W = 3;

    // Entry k lives in bits [4k+3:4k].
    localparam logic [15:0] FULL_TABLE = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
    localparam logic [31:0] HALF_TABLE = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                          4'b0110, 4'b0010, 4'b0011, 4'b0001};

    function automatic logic [3:0] full_pattern(input logic [1:0] idx);
        return FULL_TABLE[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] half_pattern(input logic [2:0] idx);
        return HALF_TABLE[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/myip_stepper_phase_gen_if.sv
// -----------------------------------------------------------------------------
// myip_stepper_phase_gen_if
// Bundle between the register file (master) and the phase generator (slave).
//   Control (master -> slave): en, start, stop, dir, period, steps
//                              [half when STEPPER_HALF_STEP_EN is defined]
//   Status  (slave -> master): coil, busy, done, pos, state_dbg
// Handshake: start and stop are single-cycle pulses sampled on the rising
// clock edge; there is no ready back-pressure. start is only acted on in IDLE
// with en=1 and stop=0; busy reports whether the move is in progress.
// -----------------------------------------------------------------------------
interface myip_stepper_phase_gen_if #(
    parameter int STEP_W = 16,
    parameter int PER_W  = 32
);
    logic              en;
    logic              start;
    logic              stop;
    logic              dir;
    logic [PER_W-1:0]  period;
    logic [STEP_W-1:0] steps;
`ifdef STEPPER_HALF_STEP_EN
    logic              half;
`endif
    logic [3:0]        coil;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] pos;
    logic [0:0]        state_dbg;

    modport master (
        output en, start, stop, dir, period, steps,
`ifdef STEPPER_HALF_STEP_EN
        output half,
`endif
        input  coil, busy, done, pos, state_dbg
    );

    modport slave (
        input  en, start, stop, dir, period, steps,
`ifdef STEPPER_HALF_STEP_EN
        input  half,
`endif
        output coil, busy, done, pos, state_dbg
    );
endinterface

// File: rtl/myip_stepper_phase_gen_rate_timer.sv
// -----------------------------------------------------------------------------
// stepper_rate_timer
// Period down-counter. A load takes priority; otherwise the count decrements
// while enabled. tick_o is high in the cycle the enabled count sits at zero.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i on this edge
//   load_val_i    : value to load (period - 1)
//   en_i          : count enable
//   tick_o        : count reached zero while enabled
// -----------------------------------------------------------------------------
module stepper_rate_timer #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tick_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/myip_stepper_phase_gen.sv
// -----------------------------------------------------------------------------
// myip_stepper_phase_gen
// Stepper sequencing core. Issues one step every `period` clocks until
// `steps` steps are issued (0 = run until stop or en low), driving a
// registered coil pattern and a wrapping signed position counter.
//   s00_axi_aclk    : clock
//   s00_axi_aresetn : asynchronous active-low reset
//   bus (slave)     : en/start/stop/dir/period/steps in; coil/busy/done/pos/
//                     state_dbg out (see myip_stepper_phase_gen_if)
// Optional: STEPPER_HALF_STEP_EN adds bus.half and the 8-entry half-step table.
// -----------------------------------------------------------------------------
module myip_stepper_phase_gen
    import stepper_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int PER_W  = 32
) (
    input  logic                     s00_axi_aclk,
    input  logic                     s00_axi_aresetn,
    myip_stepper_phase_gen_if.slave  bus
);
    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_RUN  = ST_RUN;

`ifdef STEPPER_HALF_STEP_EN
    localparam int IDX_W = HALF_IDX_W;
`else
    localparam int IDX_W = FULL_IDX_W;
`endif

    logic [0:0]        state_q, state_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              counted_q, counted_d;
    logic              dir_q, dir_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STEP_W-1:0] pos_q, pos_d;
    logic [3:0]        coil_q, coil_d;
    logic              done_q, done_d;
`ifdef STEPPER_HALF_STEP_EN
    logic              half_q, half_d;
`endif

    logic [PER_W-1:0]  per_clamped;
    logic              start_go;
    logic              run;
    logic              tick;
    logic              step;
    logic              last_step;
    logic              tmr_load;
    logic [PER_W-1:0]  tmr_load_val;

    assign per_clamped = (bus.period < PER_W'(PERIOD_MIN)) ? PER_W'(PERIOD_MIN) : bus.period;
    assign run         = (state_q == S_RUN);
    assign start_go    = (state_q == S_IDLE) && bus.start && !bus.stop && bus.en;
    // A zero count issues a step even if stop arrives in the same cycle;
    // dropping en suppresses it.
    assign step        = run && tick && bus.en;
    assign last_step   = step && counted_q && (rem_q == STEP_W'(1));

    // Reload on every zero count so the cadence stays exactly `period`.
    assign tmr_load     = start_go || tick;
    assign tmr_load_val = start_go ? (per_clamped - PER_W'(1)) : (per_q - PER_W'(1));

    stepper_rate_timer #(.W(PER_W)) u_rate_timer (
        .clk_i      (s00_axi_aclk),
        .rst_ni     (s00_axi_aresetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (run),
        .tick_o     (tick)
    );

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        rem_d     = rem_q;
        counted_d = counted_q;
        dir_d     = dir_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        coil_d    = 4'b0000;
`ifdef STEPPER_HALF_STEP_EN
        half_d    = half_q;
`endif

        if (start_go) begin
            state_d   = S_RUN;
            per_d     = per_clamped;
            rem_d     = bus.steps;
            counted_d = (bus.steps != '0);
            dir_d     = bus.dir;
`ifdef STEPPER_HALF_STEP_EN
            // In full mode idx holds the full index in [1:0]; switching mode
            // remaps so the coil pattern is unchanged (full k == half 2k+1).
            half_d = bus.half;
            if (bus.half && !half_q) begin
                idx_d = {idx_q[1:0], 1'b1};
            end else if (!bus.half && half_q) begin
                idx_d = {1'b0, idx_q[2:1]};
            end
`endif
        end else if (run) begin
            if (step) begin
`ifdef STEPPER_HALF_STEP_EN
                if (half_q) begin
                    idx_d = dir_q ? (idx_q + 3'd1) : (idx_q - 3'd1);
                end else begin
                    idx_d = {1'b0, (dir_q ? (idx_q[1:0] + 2'd1) : (idx_q[1:0] - 2'd1))};
                end
`else
                idx_d = dir_q ? (idx_q + 2'd1) : (idx_q - 2'd1);
`endif
                pos_d = dir_q ? (pos_q + STEP_W'(1)) : (pos_q - STEP_W'(1));
                if (counted_q) begin
                    rem_d = rem_q - STEP_W'(1);
                end
            end
            if (bus.stop || !bus.en || last_step) begin
                state_d = S_IDLE;
            end
            done_d = last_step;
        end

        if (bus.en) begin
`ifdef STEPPER_HALF_STEP_EN
            coil_d = half_d ? half_pattern(idx_d) : full_pattern(idx_d[1:0]);
`else
            coil_d = full_pattern(idx_d);
`endif
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q   <= S_IDLE;
            per_q     <= PER_W'(PERIOD_MIN);
            rem_q     <= '0;
            counted_q <= 1'b0;
            dir_q     <= 1'b1;
            idx_q     <= '0;
            pos_q     <= '0;
            coil_q    <= 4'b0000;
            done_q    <= 1'b0;
`ifdef STEPPER_HALF_STEP_EN
            half_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            rem_q     <= rem_d;
            counted_q <= counted_d;
            dir_q     <= dir_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            coil_q    <= coil_d;
            done_q    <= done_d;
`ifdef STEPPER_HALF_STEP_EN
            half_q    <= half_d;
`endif
        end
    end

    assign bus.coil      = coil_q;
    assign bus.busy      = run;
    assign bus.done      = done_q;
    assign bus.pos       = pos_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_myip_stepper_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_myip_stepper_phase_gen
// Directed bench for myip_stepper_phase_gen. Inputs change 1 time unit after
// the rising edge and outputs are sampled there as well; "T0" is the cycle in
// which start is high, so start_move returns at T0+1.
// -----------------------------------------------------------------------------
module tb_myip_stepper_phase_gen;
    import stepper_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    myip_stepper_phase_gen_if #(.STEP_W(16), .PER_W(32)) bus_if ();

    myip_stepper_phase_gen #(.STEP_W(16), .PER_W(32)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .bus             (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_idle();
        bus_if.en     = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.stop   = 1'b0;
        bus_if.dir    = 1'b1;
        bus_if.period = 32'd2;
        bus_if.steps  = 16'd0;
`ifdef STEPPER_HALF_STEP_EN
        bus_if.half   = 1'b0;
`endif
    endtask

    // Reset, then enable the driver so coil shows table[0] = 0011.
    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        tick(2);
        rst_n = 1'b1;
        bus_if.en = 1'b1;
        tick(1);
    endtask

    // ---------------- driver ----------------
    task automatic start_move(input logic [31:0] per, input logic [15:0] stp,
                              input logic d, input logic h);
        bus_if.period = per;
        bus_if.steps  = stp;
        bus_if.dir    = d;
`ifdef STEPPER_HALF_STEP_EN
        bus_if.half   = h;
`else
        if (h) $display("note: half-step requested in a full-step build");
`endif
        bus_if.start  = 1'b1;
        tick(1);
        bus_if.start  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus_if.en = 1'b1;
        tick(2);
        n_cmp++; if (bus_if.coil !== 4'b0000) begin n_fail++; $display("FAIL rst_coil: got %b want %b", bus_if.coil, 4'b0000); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_if.busy); end
        n_cmp++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus_if.done); end
        n_cmp++; if (bus_if.pos !== 16'h0000) begin n_fail++; $display("FAIL rst_pos: got %h want 0000", bus_if.pos); end
        n_cmp++; if (bus_if.state_dbg !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %b want 0", bus_if.state_dbg); end
        rst_n = 1'b1;
        bus_if.en = 1'b0;
        tick(1);
        n_cmp++; if (bus_if.coil !== 4'b0000) begin n_fail++; $display("FAIL rst_en0_coil: got %b want %b", bus_if.coil, 4'b0000); end
        bus_if.en = 1'b1;
        tick(1);
        n_cmp++; if (bus_if.coil !== 4'b0011) begin n_fail++; $display("FAIL rst_en1_coil: got %b want %b", bus_if.coil, 4'b0011); end
    endtask

    task automatic test_counted_forward();
        apply_reset();
        start_move(32'd4, 16'd3, 1'b1, 1'b0);                       // now T0+1
        n_cmp++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL fwd_busy_t1: got %b want 1", bus_if.busy); end
        n_cmp++; if (bus_if.coil !== 4'b0011) begin n_fail++; $display("FAIL fwd_coil_t1: got %b want %b", bus_if.coil, 4'b0011); end
        tick(3);                                                    // T0+4
        n_cmp++; if (bus_if.coil !== 4'b0011) begin n_fail++; $display("FAIL fwd_coil_t4: got %b want %b", bus_if.coil, 4'b0011); end
        tick(1);                                                    // T0+5
        n_cmp++; if (bus_if.coil !== 4'b0110) begin n_fail++; $display("FAIL fwd_coil_t5: got %b want %b", bus_if.coil, 4'b0110); end
        n_cmp++; if (bus_if.pos !== 16'd1) begin n_fail++; $display("FAIL fwd_pos_t5: got %h want 0001", bus_if.pos); end
        tick(4);                                                    // T0+9
        n_cmp++; if (bus_if.coil !== 4'b1100) begin n_fail++; $display("FAIL fwd_coil_t9: got %b want %b", bus_if.coil, 4'b1100); end
        tick(3);                                                    // T0+12
        n_cmp++; if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL fwd_t12: got done=%b busy=%b want done=0 busy=1", bus_if.done, bus_if.busy); end
        tick(1);                                                    // T0+13
        n_cmp++; if (bus_if.coil !== 4'b1001) begin n_fail++; $display("FAIL fwd_coil_t13: got %b want %b", bus_if.coil, 4'b1001); end
        n_cmp++; if (bus_if.done !== 1'b1) begin n_fail++; $display("FAIL fwd_done_t13: got %b want 1", bus_if.done); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL fwd_busy_t13: got %b want 0", bus_if.busy); end
        n_cmp++; if (bus_if.pos !== 16'd3) begin n_fail++; $display("FAIL fwd_pos_t13: got %h want 0003", bus_if.pos); end
        tick(1);                                                    // T0+14
        n_cmp++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL fwd_done_t14: got %b want 0", bus_if.done); end
    endtask

    task automatic test_reverse_wrap();
        apply_reset();
        start_move(32'd2, 16'd2, 1'b0, 1'b0);
        tick(2);                                                    // T0+3
        n_cmp++; if (bus_if.coil !== 4'b1001) begin n_fail++; $display("FAIL rev_coil_1: got %b want %b", bus_if.coil, 4'b1001); end
        n_cmp++; if (bus_if.pos !== 16'hFFFF) begin n_fail++; $display("FAIL rev_pos_1: got %h want FFFF", bus_if.pos); end
        n_cmp++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL rev_done_1: got %b want 0", bus_if.done); end
        tick(2);                                                    // T0+5
        n_cmp++; if (bus_if.coil !== 4'b1100) begin n_fail++; $display("FAIL rev_coil_2: got %b want %b", bus_if.coil, 4'b1100); end
        n_cmp++; if (bus_if.pos !== 16'hFFFE) begin n_fail++; $display("FAIL rev_pos_2: got %h want FFFE", bus_if.pos); end
        n_cmp++; if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rev_end: got done=%b busy=%b want done=1 busy=0", bus_if.done, bus_if.busy); end
        tick(1);
        n_cmp++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL rev_done_once: got %b want 0", bus_if.done); end
    endtask

    task automatic test_continuous_stop();
        int done_seen;
        done_seen = 0;
        apply_reset();
        start_move(32'd3, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin                          // to T0+31
            tick(1);
            if (bus_if.done === 1'b1) done_seen++;
        end
        n_cmp++; if (bus_if.pos !== 16'd10) begin n_fail++; $display("FAIL cont_pos_10: got %h want 000A", bus_if.pos); end
        n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL cont_no_done: got %0d pulses want 0", done_seen); end
        bus_if.stop = 1'b1;
        tick(1);
        bus_if.stop = 1'b0;
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", bus_if.busy); end
        n_cmp++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL stop_done: got %b want 0", bus_if.done); end
        n_cmp++; if (bus_if.coil !== 4'b1100) begin n_fail++; $display("FAIL stop_coil: got %b want %b", bus_if.coil, 4'b1100); end
        tick(4);
        n_cmp++; if (bus_if.pos !== 16'd10) begin n_fail++; $display("FAIL stop_pos_hold: got %h want 000A", bus_if.pos); end
    endtask

    task automatic test_clamp();
        apply_reset();
        start_move(32'd1, 16'd2, 1'b1, 1'b0);
        tick(1);                                                    // T0+2
        n_cmp++; if (bus_if.pos !== 16'd0) begin n_fail++; $display("FAIL clamp_pos_t2: got %h want 0000", bus_if.pos); end
        tick(1);                                                    // T0+3
        n_cmp++; if (bus_if.pos !== 16'd1 || bus_if.coil !== 4'b0110) begin n_fail++; $display("FAIL clamp_t3: got pos=%h coil=%b want pos=0001 coil=0110", bus_if.pos, bus_if.coil); end
        tick(2);                                                    // T0+5
        n_cmp++; if (bus_if.pos !== 16'd2 || bus_if.done !== 1'b1) begin n_fail++; $display("FAIL clamp_t5: got pos=%h done=%b want pos=0002 done=1", bus_if.pos, bus_if.done); end
    endtask

    task automatic test_start_stop_same();
        apply_reset();
        bus_if.stop = 1'b1;
        start_move(32'd2, 16'd1, 1'b1, 1'b0);
        bus_if.stop = 1'b0;
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL ss_busy: got %b want 0", bus_if.busy); end
        tick(4);
        n_cmp++; if (bus_if.pos !== 16'd0 || bus_if.coil !== 4'b0011) begin n_fail++; $display("FAIL ss_nomove: got pos=%h coil=%b want pos=0000 coil=0011", bus_if.pos, bus_if.coil); end
    endtask

    task automatic test_start_during_run();
        apply_reset();
        start_move(32'd4, 16'd2, 1'b1, 1'b0);                       // T0+1
        tick(1);                                                    // T0+2
        start_move(32'd2, 16'd5, 1'b0, 1'b0);                       // T0+3, ignored
        tick(2);                                                    // T0+5
        n_cmp++; if (bus_if.pos !== 16'd1) begin n_fail++; $display("FAIL sdr_pos_t5: got %h want 0001", bus_if.pos); end
        tick(3);                                                    // T0+8
        n_cmp++; if (bus_if.pos !== 16'd1 || bus_if.done !== 1'b0) begin n_fail++; $display("FAIL sdr_t8: got pos=%h done=%b want pos=0001 done=0", bus_if.pos, bus_if.done); end
        tick(1);                                                    // T0+9
        n_cmp++; if (bus_if.pos !== 16'd2 || bus_if.done !== 1'b1 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL sdr_t9: got pos=%h done=%b busy=%b want 0002/1/0", bus_if.pos, bus_if.done, bus_if.busy); end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        start_move(32'd4, 16'd0, 1'b1, 1'b0);
        tick(4);                                                    // T0+5
        n_cmp++; if (bus_if.coil !== 4'b0110) begin n_fail++; $display("FAIL en_pre_coil: got %b want %b", bus_if.coil, 4'b0110); end
        bus_if.en = 1'b0;
        tick(1);
        n_cmp++; if (bus_if.coil !== 4'b0000 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL en_off: got coil=%b busy=%b want 0000/0", bus_if.coil, bus_if.busy); end
        tick(5);
        n_cmp++; if (bus_if.pos !== 16'd1) begin n_fail++; $display("FAIL en_pos_hold: got %h want 0001", bus_if.pos); end
        bus_if.en = 1'b1;
        tick(1);
        n_cmp++; if (bus_if.coil !== 4'b0110) begin n_fail++; $display("FAIL en_idx_kept: got %b want %b", bus_if.coil, 4'b0110); end
    endtask

    task automatic test_reset_mid_move();
        apply_reset();
        start_move(32'd2, 16'd0, 1'b1, 1'b0);
        tick(4);                                                    // T0+5
        n_cmp++; if (bus_if.pos !== 16'd2 || bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got pos=%h busy=%b want 0002/1", bus_if.pos, bus_if.busy); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus_if.coil !== 4'b0000 || bus_if.busy !== 1'b0 || bus_if.pos !== 16'd0 || bus_if.done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async: got coil=%b busy=%b pos=%h done=%b want 0000/0/0000/0", bus_if.coil, bus_if.busy, bus_if.pos, bus_if.done);
        end
        tick(1);
        rst_n = 1'b1;
    endtask

`ifdef STEPPER_HALF_STEP_EN
    task automatic test_half_step();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b0010, 4'b0110, 4'b0100, 4'b1100};
        apply_reset();
        start_move(32'd2, 16'd4, 1'b1, 1'b1);
        n_cmp++; if (bus_if.coil !== 4'b0011) begin n_fail++; $display("FAIL half_coil_0: got %b want %b", bus_if.coil, 4'b0011); end
        for (int i = 0; i < 4; i++) begin
            tick(2);
            n_cmp++; if (bus_if.coil !== exp_seq[i]) begin n_fail++; $display("FAIL half_coil_%0d: got %b want %b", i + 1, bus_if.coil, exp_seq[i]); end
        end
        n_cmp++; if (bus_if.done !== 1'b1 || bus_if.pos !== 16'd4) begin n_fail++; $display("FAIL half_end: got done=%b pos=%h want 1/0004", bus_if.done, bus_if.pos); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive_idle();
        test_reset();
        test_counted_forward();
        test_reverse_wrap();
        test_continuous_stop();
        test_clamp();
        test_start_stop_same();
        test_start_during_run();
        test_enable_drop();
        test_reset_mid_move();
`ifdef STEPPER_HALF_STEP_EN
        test_half_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/myip_stepper_phase_gen.md
# myip_stepper_phase_gen

Stepper-motor sequencing core that sits directly downstream of the myip_stepper AXI4-Lite register file. It consumes the decoded control/period/step-count registers and produces the registered coil drive pattern, busy/done status, and a signed position counter that is read back through the register file. One step is issued every `period` clocks until `steps` have been issued, or until stopped.

## Interface
- STEP_W, 16: width of step count and position counter
- PER_W, 32: width of the period (clocks per step)

- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- en  in  1  driver enable; 0 de-energizes the coils and aborts a move
- start  in  1  single-cycle pulse; begins a move when in IDLE
- stop  in  1  single-cycle pulse; ends a move at the next edge
- dir  in  1  1 = forward (phase index +1), 0 = reverse (−1)
- period  in  PER_W  clocks per step; values 0 and 1 are clamped to 2
- steps  in  STEP_W  steps to issue; 0 = run continuously until stop/en low
- coil  out  4  registered coil pattern {B', A', B, A}
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on completion of a counted move
- pos  out  STEP_W  position counter; two's complement, wraps modulo 2^STEP_W

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN when start=1, stop=0, and en=1. On that edge: latch dir, the clamped period, and steps; load the rate counter with period−1.
  - RUN → IDLE when stop=1, en=0, or the final counted step is issued.
- Rate counter: in RUN, decrements each cycle. When it is 0, one step is issued on that edge and the counter reloads period−1.
- On each step:
  - Phase index moves ±1 modulo table length.
  - pos moves ±1 with wrap.
  - If steps≠0, the remaining count decrements.
  - When remaining reaches 0, the FSM returns to IDLE and done pulses.
- Full-step table, index 0..3: 0011, 0110, 1100, 1001.
- coil is registered as en ? table[idx] : 0000. The phase index is kept while en=0.
- Boundary rules:
  - start while in RUN: ignored.
  - start and stop in the same cycle: stop wins, no move begins.
  - stop or en low in RUN: no further step, done not pulsed, pos keeps its value.
  - Input changes during RUN: ignored, because the move uses the latched values.
  - pos wraps: 0 − 1 = 2^STEP_W − 1.
  - Reset mid-move: all state returns to reset values immediately (asynchronous reset).

## Timing
- Reset values: coil=0000, busy=0, done=0, pos=0, phase index 0, state IDLE.
- With start sampled in cycle T0:
  - busy=1 from T0+1.
  - First coil change is visible at T0+1+p, where p is the clamped period.
  - Subsequent coil changes follow every p cycles.
- Final counted step: coil update, pos update, done=1, and busy=0 are all visible in the same cycle. done lasts exactly one cycle.
- stop sampled in cycle Ts: busy=0 at Ts+1. A step is still issued at Ts's edge if the counter was 0.
- en change: coil responds one cycle later.

## Configuration
- STEPPER_HALF_STEP_EN defined:
  - Adds input port half (1 bit), latched at start.
  - When half=1, the 8-entry half-step table is used: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Phase index is 3 bits. On entry to half mode, full-step index k maps to half index 2k+1.
- STEPPER_HALF_STEP_EN undefined:
  - No half port.
  - Full-step table only; 2-bit index.

## Structure
- Package stepper_pkg contains:
  - state enum (IDLE, RUN)
  - PERIOD_MIN=2
  - full-step and half-step phase table constants
  - phase-index width localparams
- One sub-module, stepper_rate_timer: period down-counter with load, enable, and a tick output, instantiated once.

## Test plan
- Counted forward move: reset, en=1, period=4, steps=3, dir=1.
  - coil 0011 → 0110 at T0+5, 1100 at T0+9, 1001 at T0+13.
  - done pulses at T0+13.
  - pos=3.
- Reverse wrap: from pos=0, idx 0, period=2, steps=2, dir=0.
  - coil 1001 then 1100.
  - pos=0xFFFE, done pulses once.
- Continuous run and stop: steps=0, period=3; stop pulsed after 10 steps.
  - busy drops the next cycle, done stays 0, pos=10.
- Clamp and collisions:
  - period=1 gives steps every 2 cycles.
  - start and stop in the same cycle: no move.
  - start during RUN: ignored.
- Enable and reset: en=0 mid-move gives coil=0000 the next cycle, busy=0, and pos is held. Reset asserted mid-move gives all outputs at reset values immediately.
- Half-step (STEPPER_HALF_STEP_EN defined): half=1, steps=4, dir=1 from idx 0.
  - coil sequence 0011 → 0010 → 0110 → 0100 → 1100.
